// File: rtl/nibble_arbiter.sv
// nibble_arbiter: two-source round-robin arbiter feeding one registered
// 4-bit output stage through a shared 2:1 nibble mux, with per-source
// grant counters.

// Shared datapath mux: selects source B when i_sel is high.
module mux4bit_sel (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_sel,
  output logic [3:0] o_y
);
  assign o_y = i_sel ? i_b : i_a;
endmodule

module nibble_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [3:0]       a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [3:0]       b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             y_valid,
  output logic [3:0]       y_data,
  input  logic             y_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;      // 0 = A granted last, 1 = B granted last
  logic [3:0]       r_y_data;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;

  logic             w_can_accept;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_any_grant;
  logic [3:0]       w_mux_y;

  // Readies are also held low while rst_n is asserted: a beat taken during
  // reset would be thrown away, so the arbiter must not claim it.
  assign w_can_accept = rst_n & ((r_state == S_EMPTY) | y_ready);
  assign w_grant_a    = w_can_accept & a_valid & (~b_valid | r_last);
  assign w_grant_b    = w_can_accept & b_valid & (~a_valid | ~r_last);
  assign w_any_grant  = w_grant_a | w_grant_b;

  assign a_ready = w_grant_a;
  assign b_ready = w_grant_b;
  assign sel     = w_grant_b;

  mux4bit_sel u_mux (
    .i_a   (a_data),
    .i_b   (b_data),
    .i_sel (w_grant_b),
    .o_y   (w_mux_y)
  );

  // Output-stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Output-stage next state: a grant always fills; a drain without refill empties.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_any_grant) w_state_nxt = S_FULL;
      S_FULL:  if (y_ready && !w_any_grant) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Output-stage outputs decoded from state.
  always_comb begin
    y_valid = (r_state == S_FULL);
  end

  // Winning nibble capture and round-robin pointer update; both hold without a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_data <= 4'h0;
      r_last   <= 1'b1;  // so A wins the first tie
    end else if (w_any_grant) begin
      r_y_data <= w_mux_y;
      r_last   <= w_grant_b;
    end
  end

  // Grant counters; clear wins over a same-cycle grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (cnt_clr) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (w_grant_a) r_cnt_a <= r_cnt_a + CNT_W'(1);
      if (w_grant_b) r_cnt_b <= r_cnt_b + CNT_W'(1);
    end
  end

  assign y_data = r_y_data;
  assign cnt_a  = r_cnt_a;
  assign cnt_b  = r_cnt_b;

endmodule
